// File: rtl/iir6_pkg.sv
// Shared constants, state encoding and result scaling for the 6th-order IIR filter.
// Optional feature: define IIR6_SAT_EN to clamp out-of-range results instead of wrapping.
package iir6_pkg;

   localparam int DW    = 32;
   localparam int FRAC  = 30;
   localparam int ACC_W = 72;
   localparam int NTAPS = 13;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Apply the coefficient pre-scale, drop the fraction bits and fit the result to DW bits.
   function automatic logic signed [DW-1:0] scale_result(input logic signed [ACC_W-1:0] acc,
                                                         input logic [2:0] scale);
      logic signed [ACC_W-1:0] sh;
      logic signed [DW-1:0]    res;
      sh = (acc <<< scale) >>> FRAC;
`ifdef IIR6_SAT_EN
      // In range only when every bit above the DW sign bit matches the sign bit.
      if ((sh[ACC_W-1:DW-1] == {(ACC_W-DW+1){1'b0}}) || (sh[ACC_W-1:DW-1] == {(ACC_W-DW+1){1'b1}})) begin
         res = sh[DW-1:0];
      end else if (sh[ACC_W-1]) begin
         res = 32'sh8000_0000;
      end else begin
         res = 32'sh7FFF_FFFF;
      end
`else
      res = sh[DW-1:0];
`endif
      return res;
   endfunction

endpackage

// File: rtl/iir6_32bit_fixed_if.sv
// Sample, coefficient and result bundle of the IIR filter.
interface iir6_32bit_fixed_if
   import iir6_pkg::*;
   ();
   logic signed [DW-1:0] audio_in;
   logic                 data_val;
   logic [2:0]           scale;
   logic signed [DW-1:0] b1, b2, b3, b4, b5, b6, b7;
   logic signed [DW-1:0] a2, a3, a4, a5, a6, a7;
   logic signed [DW-1:0] audio_out;
   logic                 audio_out_val;

   modport master (
      output audio_in, data_val, scale,
      output b1, b2, b3, b4, b5, b6, b7,
      output a2, a3, a4, a5, a6, a7,
      input  audio_out, audio_out_val
   );

   modport slave (
      input  audio_in, data_val, scale,
      input  b1, b2, b3, b4, b5, b6, b7,
      input  a2, a3, a4, a5, a6, a7,
      output audio_out, audio_out_val
   );
endinterface

// File: rtl/iir6_mac.sv
// Single time-shared signed multiply-accumulate: full-width product sign-extended into the accumulator.
module iir6_mac
   import iir6_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [DW-1:0]    coef_i,
   input  logic signed [DW-1:0]    data_i,
   output logic signed [ACC_W-1:0] acc_o
);
   logic signed [2*DW-1:0]  prod_s;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   assign prod_s = coef_i * data_i;
   assign acc_o  = acc_q;

   // Next accumulator value: clear on a new sample, add one product per enabled cycle.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = {ACC_W{1'b0}};
      end else if (en_i) begin
         acc_d = acc_q + {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= {ACC_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end
endmodule

// File: rtl/iir6_32bit_fixed.sv
// 6th-order direct-form-I IIR filter, signed 32-bit fixed point, one shared MAC (13 taps per sample).
// Optional feature: define IIR6_SAT_EN to saturate the output (and fed-back y1) instead of wrapping.
module iir6_32bit_fixed
   import iir6_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   iir6_32bit_fixed_if.slave  bus
);
   logic [1:0]              state_q, state_d;
   logic [3:0]              idx_q, idx_d;
   logic signed [DW-1:0]    x_q [7];   // x_q[0] = x0 .. x_q[6] = x6
   logic signed [DW-1:0]    y_q [6];   // y_q[0] = y1 .. y_q[5] = y6
   logic signed [DW-1:0]    out_q;
   logic                    val_q;
   logic signed [DW-1:0]    coef_s, data_s;
   logic signed [ACC_W-1:0] acc_s;
   logic signed [DW-1:0]    y_s;
   logic                    start_s;

   assign start_s           = (state_q == ST_IDLE) && bus.data_val;
   assign y_s               = scale_result(acc_s, bus.scale);
   assign bus.audio_out     = out_q;
   assign bus.audio_out_val = val_q;

   iir6_mac u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start_s),
      .en_i   (state_q == ST_MAC),
      .coef_i (coef_s),
      .data_i (data_s),
      .acc_o  (acc_s)
   );

   // Sequencer: wait for a strobe, walk the 13 taps, then one result cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.data_val) begin
               state_d = ST_MAC;
               idx_d   = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (idx_q == 4'(NTAPS - 1)) begin
               state_d = ST_DONE;
               idx_d   = 4'd0;
            end else begin
               idx_d   = idx_q + 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            idx_d   = 4'd0;
         end
      endcase
   end

   // Operand mux: feed-forward taps first, then feedback taps.
   always_comb begin
      coef_s = {DW{1'b0}};
      data_s = {DW{1'b0}};
      case (idx_q)
         4'd0:    begin coef_s = bus.b1; data_s = x_q[0]; end
         4'd1:    begin coef_s = bus.b2; data_s = x_q[1]; end
         4'd2:    begin coef_s = bus.b3; data_s = x_q[2]; end
         4'd3:    begin coef_s = bus.b4; data_s = x_q[3]; end
         4'd4:    begin coef_s = bus.b5; data_s = x_q[4]; end
         4'd5:    begin coef_s = bus.b6; data_s = x_q[5]; end
         4'd6:    begin coef_s = bus.b7; data_s = x_q[6]; end
         4'd7:    begin coef_s = bus.a2; data_s = y_q[0]; end
         4'd8:    begin coef_s = bus.a3; data_s = y_q[1]; end
         4'd9:    begin coef_s = bus.a4; data_s = y_q[2]; end
         4'd10:   begin coef_s = bus.a5; data_s = y_q[3]; end
         4'd11:   begin coef_s = bus.a6; data_s = y_q[4]; end
         4'd12:   begin coef_s = bus.a7; data_s = y_q[5]; end
         default: begin coef_s = {DW{1'b0}}; data_s = {DW{1'b0}}; end
      endcase
   end

   // State, sample capture, result register and history shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 4'd0;
         out_q   <= {DW{1'b0}};
         val_q   <= 1'b0;
         for (int i = 0; i < 7; i++) x_q[i] <= {DW{1'b0}};
         for (int i = 0; i < 6; i++) y_q[i] <= {DW{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         val_q   <= (state_q == ST_DONE);
         if (start_s) begin
            x_q[0] <= bus.audio_in;
         end
         if (state_q == ST_DONE) begin
            out_q <= y_s;
            for (int i = 6; i > 0; i--) x_q[i] <= x_q[i-1];
            for (int i = 5; i > 0; i--) y_q[i] <= y_q[i-1];
            y_q[0] <= y_s;
         end
      end
   end
endmodule

// File: tb/tb_iir6_32bit_fixed.sv
// Scoreboard bench for iir6_32bit_fixed: stimulus pushes expected results, a monitor checks each output pulse.
module tb_iir6_32bit_fixed;
   import iir6_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   iir6_32bit_fixed_if bus ();

   iir6_32bit_fixed dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] val;
      int          cyc;
      bit          chk;
   } exp_t;

   exp_t sb[$];
   int cyc      = 0;
   int n_assert = 0;
   int n_fail   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every output pulse must match the oldest pending expectation in value and timing.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.audio_out_val === 1'b1) begin
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_val: got audio_out_val=1 (out=%h) expected no pulse (t=%0t)",
                     bus.audio_out, $time);
         end else begin
            e = sb.pop_front();
            if (e.chk) check("audio_out", bus.audio_out, e.val);
            check("latency_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic zero_coefs();
      {bus.b1, bus.b2, bus.b3, bus.b4, bus.b5, bus.b6, bus.b7} = {7{32'h0}};
      {bus.a2, bus.a3, bus.a4, bus.a5, bus.a6, bus.a7} = {6{32'h0}};
      bus.scale = 3'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // One-cycle strobe; returns after the sampling edge.
   task automatic strobe(input logic [31:0] x);
      @(negedge clk);
      bus.audio_in = x;
      bus.data_val = 1'b1;
      @(posedge clk);
      #1;
      bus.data_val = 1'b0;
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] exp);
      strobe(x);
      sb.push_back('{exp, cyc + 14, 1'b1});
      repeat (16) @(posedge clk);
   endtask

   initial begin
      bus.audio_in = 32'h0;
      bus.data_val = 1'b0;
      zero_coefs();
      repeat (3) @(negedge clk);
      check("reset_audio_out", bus.audio_out, 32'h0);
      check("reset_val", {31'h0, bus.audio_out_val}, 32'h0);
      rst = 1'b1;

      // Pass-through impulse
      zero_coefs();
      bus.b1 = 32'h4000_0000;
      send(32'h1234_5678, 32'h1234_5678);
      send(32'h0000_0000, 32'h0000_0000);

      // Scale and one-sample delay
      do_reset();
      zero_coefs();
      bus.b2 = 32'h0800_0000;
      bus.scale = 3'd3;
      send(32'd1000, 32'd0);
      send(32'd0, 32'd1000);

      // First-order feedback converging towards 0x2000_0000
      do_reset();
      zero_coefs();
      bus.b1 = 32'h4000_0000;
      bus.a2 = 32'h2000_0000;
      send(32'h1000_0000, 32'h1000_0000);
      send(32'h1000_0000, 32'h1800_0000);
      send(32'h1000_0000, 32'h1C00_0000);
      send(32'h1000_0000, 32'h1E00_0000);
      send(32'h1000_0000, 32'h1F00_0000);
      send(32'h1000_0000, 32'h1F80_0000);

      // Overflow, positive and negative
      do_reset();
      zero_coefs();
      bus.b1 = 32'h4000_0000;
      bus.b2 = 32'h4000_0000;
      send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
`ifdef IIR6_SAT_EN
      send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
`else
      send(32'h7FFF_FFFF, 32'hFFFF_FFFE);
`endif
      do_reset();
      send(32'h8000_0000, 32'h8000_0000);
`ifdef IIR6_SAT_EN
      send(32'h8000_0000, 32'h8000_0000);
`else
      send(32'h8000_0000, 32'h0000_0000);
`endif

      // Reset mid-computation: immediate clear, no pulse, history wiped
      do_reset();
      send(32'd100, 32'd100);
      send(32'd200, 32'd300);
      strobe(32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midreset_audio_out", bus.audio_out, 32'h0);
      check("midreset_val", {31'h0, bus.audio_out_val}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(posedge clk);
      send(32'd1, 32'd1);

      // Busy strobe at idx 5 is ignored
      do_reset();
      zero_coefs();
      bus.b2 = 32'h4000_0000;
      strobe(32'd5);
      sb.push_back('{32'd0, cyc + 14, 1'b1});
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.audio_in = 32'd99;
      bus.data_val = 1'b1;
      @(posedge clk);
      #1;
      bus.data_val = 1'b0;
      repeat (14) @(posedge clk);
      send(32'd0, 32'd5);

      // Butterworth low-pass square wave: exactly one timely pulse per strobe
      do_reset();
      bus.b1 = 32'h0000_226C; bus.b2 = 32'h0000_CE8B; bus.b3 = 32'h0002_045B;
      bus.b4 = 32'h0002_B07A; bus.b5 = 32'h0002_045B; bus.b6 = 32'h0000_CE8B;
      bus.b7 = 32'h0000_226C;
      bus.a2 = 32'h21DC_9D38; bus.a3 = 32'hC2BA_BD8C; bus.a4 = 32'h3C58_991F;
      bus.a5 = 32'hDDFD_B62D; bus.a6 = 32'h0A5F_A11C; bus.a7 = 32'hFEAA_19B2;
      bus.scale = 3'd3;
      for (int i = 0; i < 24; i++) begin
         strobe(((i / 8) % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0001);
         sb.push_back('{32'd0, cyc + 14, 1'b0});
         repeat (19) @(posedge clk);
      end

      // Drain with a bounded wait
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
      if (sb.size() != 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
      end
      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
